modrm_fetch: RTL and testbench

Instruction-front-end stage that consumes the byte stream from the prefetch queue and assembles prefixes, opcode, ModR/M and displacement into one registered decode record. It sits directly upstream of the physical address calculator and drives its `mod`, `rm`, `displacement` and `segment_override` inputs. It also gives the execution unit the opcode, the reg field and the instruction length.

---
 rtl/modrm_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_modrm_fetch.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modrm_fetch.sv
// -----------------------------------------------------------------------------
// modrm_fetch
//
// Instruction front-end stage. Pulls bytes from the prefetch queue one at a
// time and assembles segment / REP / LOCK prefixes, the opcode, the ModR/M
// byte and an optional 8- or 16-bit displacement into one registered decode
// record. The record feeds the physical address calculator (mod, rm,
// displacement, segment_override) and the execution unit (opcode, reg_field,
// length).
//
// Ports
//   clk               single clock, all state changes on its rising edge
//   reset             synchronous, active-high
//   flush             drops any partial or held record
//   in_valid/in_data  prefetch byte stream
//   in_ready          byte accepted when in_valid && in_ready
//   out_valid         decode record valid
//   out_ready         record taken when out_valid && out_ready
//   opcode            opcode byte
//   has_modrm         opcode carries a ModR/M byte
//   mod/reg_field/rm  ModR/M fields, 0 when !has_modrm
//   displacement      sign-extended disp8 or raw disp16, otherwise 0
//   segment_override  {present, segment[1:0]} (ES=0, CS=1, SS=2, DS=3)
//   rep               {REP seen, F3 (1) / F2 (0)}
//   lock              F0 prefix seen
//   length            bytes consumed including prefixes, saturates at 15
//
// Build option
//   MODRM_FETCH_REP_LOCK_EN  when defined, F0/F2/F3 are consumed as LOCK/REP
//                            prefixes; when undefined they decode as plain
//                            opcodes and rep/lock are tied to 0.
// -----------------------------------------------------------------------------
module modrm_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  opcode,
    output logic        has_modrm,
    output logic [1:0]  mod,
    output logic [2:0]  reg_field,
    output logic [2:0]  rm,
    output logic [15:0] displacement,
    output logic [2:0]  segment_override,
    output logic [1:0]  rep,
    output logic        lock,
    output logic [3:0]  length
);

    typedef enum logic [2:0] {
        OPC     = 3'd0,
        MODRM   = 3'd1,
        DISP_LO = 3'd2,
        DISP_HI = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t state;

    // Remembers, between MODRM and DISP_LO, whether two displacement bytes
    // follow (1) or only one (0).
    logic disp_two;

    logic       byte_take;
    logic [3:0] length_next;
    logic       is_seg_prefix;
    logic       table_hit;

    // Handshake strobes are pure state decodes; everything else is a register.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);

    assign byte_take = in_valid && in_ready;

    // Length counts every consumed byte but never wraps past 15, so a long
    // run of redundant prefixes still reports the architectural maximum.
    assign length_next = (length == 4'd15) ? 4'd15 : (length + 4'd1);

    // 26/2E/36/3E all have the form 001s_s110; bits [4:3] select the segment.
    assign is_seg_prefix = (in_data[7:5] == 3'b001) && (in_data[2:0] == 3'b110);

    // Opcodes that are followed by a ModR/M byte. The ALU block 00-3F uses the
    // low three bits 0-3 for its ModR/M forms in every row.
    function automatic logic modrm_table_hit(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        if (op[7:6] == 2'b00 && op[2] == 1'b0) begin
            hit = 1'b1;
        end else if (op[7:4] == 4'h8) begin
            hit = 1'b1;
        end else if (op[7:2] == 6'b1100_01) begin
            hit = 1'b1;
        end else if (op[7:2] == 6'b1101_00) begin
            hit = 1'b1;
        end else if (op[7:3] == 5'b1101_1) begin
            hit = 1'b1;
        end else if (op[7:4] == 4'hF && op[2:1] == 2'b11) begin
            hit = 1'b1;
        end
        return hit;
    endfunction

    assign table_hit = modrm_table_hit(in_data);

`ifdef MODRM_FETCH_REP_LOCK_EN
    logic is_rep_lock_prefix;
    assign is_rep_lock_prefix = (in_data == 8'hF0) || (in_data == 8'hF2) ||
                                (in_data == 8'hF3);
`else
    assign rep  = 2'b00;
    assign lock = 1'b0;
`endif

    // Single sequential block for the whole stage. Reset, flush and a taken
    // record all return to OPC with a zeroed record; flush is checked before
    // the handshakes so neither a byte nor the record transfers that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush || (state == HOLD && out_ready)) begin
            state            <= OPC;
            disp_two         <= 1'b0;
            opcode           <= 8'h00;
            has_modrm        <= 1'b0;
            mod              <= 2'b00;
            reg_field        <= 3'b000;
            rm               <= 3'b000;
            displacement     <= 16'h0000;
            segment_override <= 3'b000;
            length           <= 4'd0;
`ifdef MODRM_FETCH_REP_LOCK_EN
            rep              <= 2'b00;
            lock             <= 1'b0;
`endif
        end else if (byte_take) begin
            length <= length_next;
            case (state)
                OPC: begin
                    if (is_seg_prefix) begin
                        segment_override <= {1'b1, in_data[4:3]};
`ifdef MODRM_FETCH_REP_LOCK_EN
                    end else if (is_rep_lock_prefix) begin
                        if (in_data == 8'hF0) begin
                            lock <= 1'b1;
                        end else begin
                            rep <= {1'b1, in_data[0]};
                        end
`endif
                    end else begin
                        opcode <= in_data;
                        if (table_hit) begin
                            has_modrm <= 1'b1;
                            state     <= MODRM;
                        end else begin
                            state     <= HOLD;
                        end
                    end
                end

                // mod=01 -> disp8; mod=10 or direct address (mod=00,rm=110)
                // -> disp16; register form and other mod=00 have none.
                MODRM: begin
                    mod       <= in_data[7:6];
                    reg_field <= in_data[5:3];
                    rm        <= in_data[2:0];
                    if (in_data[7:6] == 2'b11) begin
                        state <= HOLD;
                    end else if (in_data[7:6] == 2'b01) begin
                        disp_two <= 1'b0;
                        state    <= DISP_LO;
                    end else if (in_data[7:6] == 2'b10 || in_data[2:0] == 3'b110) begin
                        disp_two <= 1'b1;
                        state    <= DISP_LO;
                    end else begin
                        state <= HOLD;
                    end
                end

                DISP_LO: begin
                    if (disp_two) begin
                        displacement[7:0] <= in_data;
                        state             <= DISP_HI;
                    end else begin
                        displacement <= {{8{in_data[7]}}, in_data};
                        state        <= HOLD;
                    end
                end

                DISP_HI: begin
                    displacement[15:8] <= in_data;
                    state              <= HOLD;
                end

                default: begin
                    state <= OPC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modrm_fetch.sv
// -----------------------------------------------------------------------------
// tb_modrm_fetch
//
// Bench for modrm_fetch: a table of directed instructions with expected
// records, hand-written multi-cycle sequences (back-pressure, flush, reset,
// length saturation, REP/LOCK option) and a randomized byte stream checked
// against an instruction-level decoder model.
// -----------------------------------------------------------------------------
module tb_modrm_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [1:0]  mod;
    logic [2:0]  reg_field;
    logic [2:0]  rm;
    logic [15:0] displacement;
    logic [2:0]  segment_override;
    logic [1:0]  rep;
    logic        lock;
    logic [3:0]  length;

    int total = 0;
    int bad   = 0;

    modrm_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .opcode           (opcode),
        .has_modrm        (has_modrm),
        .mod              (mod),
        .reg_field        (reg_field),
        .rm               (rm),
        .displacement     (displacement),
        .segment_override (segment_override),
        .rep              (rep),
        .lock             (lock),
        .length           (length)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic        has;
        logic [1:0]  md;
        logic [2:0]  rg;
        logic [2:0]  r;
        logic [15:0] disp;
        logic [2:0]  seg;
        logic [1:0]  rp;
        logic        lk;
        logic [3:0]  len;
    } rec_t;

    typedef struct {
        logic [5:0][7:0] bytes;
        int              n;
        rec_t            exp;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] stream[2048];
    logic [7:0] hit_ops[8] = '{8'h8B, 8'h89, 8'h01, 8'hC7, 8'hF7, 8'hD1, 8'h80, 8'hFF};

    function automatic rec_t mkRec(input logic [7:0] op, input logic has,
                                   input logic [1:0] md, input logic [2:0] rg,
                                   input logic [2:0] r, input logic [15:0] disp,
                                   input logic [2:0] seg, input logic [1:0] rp,
                                   input logic lk, input logic [3:0] len);
        rec_t e;
        e.op = op; e.has = has; e.md = md; e.rg = rg; e.r = r;
        e.disp = disp; e.seg = seg; e.rp = rp; e.lk = lk; e.len = len;
        return e;
    endfunction

    function automatic vec_t mkVec(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3,
                                   input logic [7:0] b4, input rec_t e);
        vec_t v;
        v.bytes    = '0;
        v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2;
        v.bytes[3] = b3; v.bytes[4] = b4;
        v.n   = n;
        v.exp = e;
        return v;
    endfunction

    // Opcode-level ModR/M table written as plain numeric ranges.
    function automatic bit modelHit(input logic [7:0] b);
        int v;
        v = int'(b);
        return (v < 'h40 && (v % 8) < 4) || (v >= 'h80 && v <= 'h8F) ||
               (v >= 'hC4 && v <= 'hC7) || (v >= 'hD0 && v <= 'hD3) ||
               (v >= 'hD8 && v <= 'hDF) || v == 'hF6 || v == 'hF7 ||
               v == 'hFE || v == 'hFF;
    endfunction

    // Decodes one whole instruction starting at stream[start].
    function automatic rec_t modelDecode(input int start, output int consumed);
        rec_t e;
        int   i;
        int   cnt;
        int   ndisp;
        int   m;
        int   lo;
        int   hi;
        logic [7:0] b;
        bit   done;
        e = '0;
        i = start;
        cnt = 0;
        done = 0;
        while (!done) begin
            b = stream[i];
            i++;
            cnt++;
            case (b)
                8'h26: e.seg = 3'd4;
                8'h2E: e.seg = 3'd5;
                8'h36: e.seg = 3'd6;
                8'h3E: e.seg = 3'd7;
`ifdef MODRM_FETCH_REP_LOCK_EN
                8'hF0: e.lk = 1'b1;
                8'hF2: e.rp = 2'd2;
                8'hF3: e.rp = 2'd3;
`endif
                default: done = 1;
            endcase
        end
        e.op = b;
        if (modelHit(b)) begin
            e.has = 1'b1;
            m = int'(stream[i]);
            i++;
            cnt++;
            e.md = 2'(m / 64);
            e.rg = 3'((m / 8) % 8);
            e.r  = 3'(m % 8);
            if (e.md == 2'd3)      ndisp = 0;
            else if (e.md == 2'd1) ndisp = 1;
            else if (e.md == 2'd2) ndisp = 2;
            else                   ndisp = (e.r == 3'd6) ? 2 : 0;
            if (ndisp == 1) begin
                lo = int'(stream[i]);
                i++;
                cnt++;
                e.disp = (lo >= 128) ? 16'(lo + 'hFF00) : 16'(lo);
            end else if (ndisp == 2) begin
                lo = int'(stream[i]);
                hi = int'(stream[i + 1]);
                i += 2;
                cnt += 2;
                e.disp = 16'(lo + 256 * hi);
            end
        end
        e.len = (cnt > 15) ? 4'd15 : 4'(cnt);
        consumed = cnt;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkRecord(input string tag, input rec_t e);
        checkOutput({tag, ".opcode"},    32'(opcode),           32'(e.op));
        checkOutput({tag, ".has_modrm"}, 32'(has_modrm),        32'(e.has));
        checkOutput({tag, ".mod"},       32'(mod),              32'(e.md));
        checkOutput({tag, ".reg"},       32'(reg_field),        32'(e.rg));
        checkOutput({tag, ".rm"},        32'(rm),               32'(e.r));
        checkOutput({tag, ".disp"},      32'(displacement),     32'(e.disp));
        checkOutput({tag, ".seg"},       32'(segment_override), 32'(e.seg));
        checkOutput({tag, ".rep"},       32'(rep),              32'(e.rp));
        checkOutput({tag, ".lock"},      32'(lock),             32'(e.lk));
        checkOutput({tag, ".length"},    32'(length),           32'(e.len));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Feeds n bytes back-to-back; each must be accepted in its cycle.
    task automatic applyStimulus(input string tag, input logic [5:0][7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic takeRecord(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, ".after_take_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rec_t zero_rec;
        rec_t e;
        int   ptr;
        int   mptr;
        int   used;
        int   records;
        int   cycles;
        bit   in_take;
        logic [5:0][7:0] seq;

        zero_rec = '0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        vecs[0] = mkVec(4, 8'h2E, 8'h8B, 8'h46, 8'hFC, 8'h00,
                        mkRec(8'h8B, 1, 2'b01, 3'b000, 3'b110, 16'hFFFC, 3'b101, 2'b00, 0, 4'd4));
        vecs[1] = mkVec(4, 8'h8B, 8'h0E, 8'h34, 8'h12, 8'h00,
                        mkRec(8'h8B, 1, 2'b00, 3'b001, 3'b110, 16'h1234, 3'b000, 2'b00, 0, 4'd4));
        vecs[2] = mkVec(2, 8'h01, 8'hC3, 8'h00, 8'h00, 8'h00,
                        mkRec(8'h01, 1, 2'b11, 3'b000, 3'b011, 16'h0000, 3'b000, 2'b00, 0, 4'd2));
        vecs[3] = mkVec(1, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00,
                        mkRec(8'h90, 0, 2'b00, 3'b000, 3'b000, 16'h0000, 3'b000, 2'b00, 0, 4'd1));
        vecs[4] = mkVec(4, 8'h89, 8'h86, 8'h78, 8'h56, 8'h00,
                        mkRec(8'h89, 1, 2'b10, 3'b000, 3'b110, 16'h5678, 3'b000, 2'b00, 0, 4'd4));
        vecs[5] = mkVec(5, 8'h3E, 8'h26, 8'hF7, 8'h45, 8'h7F,
                        mkRec(8'hF7, 1, 2'b01, 3'b000, 3'b101, 16'h007F, 3'b100, 2'b00, 0, 4'd5));
        vecs[6] = mkVec(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        mkRec(8'h00, 1, 2'b00, 3'b000, 3'b000, 16'h0000, 3'b000, 2'b00, 0, 4'd2));
        vecs[7] = mkVec(4, 8'hC4, 8'h06, 8'h00, 8'h80, 8'h00,
                        mkRec(8'hC4, 1, 2'b00, 3'b000, 3'b110, 16'h8000, 3'b000, 2'b00, 0, 4'd4));

        // Reset state
        doReset();
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
        checkRecord("reset", zero_rec);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            applyStimulus(tag, vecs[v].bytes, vecs[v].n);
            checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".in_ready"},  32'(in_ready),  32'd0);
            checkRecord(tag, vecs[v].exp);
            takeRecord(tag);
            checkRecord({tag, ".cleared"}, zero_rec);
        end

        // Back-pressure: record held 5 cycles, pending byte not lost
        seq = '0; seq[0] = 8'h90;
        applyStimulus("hold", seq, 1);
        in_valid = 1'b1; in_data = 8'h91;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold.in_ready",  32'(in_ready),  32'd0);
            checkOutput("hold.out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold.opcode",    32'(opcode),    32'h90);
            checkOutput("hold.length",    32'(length),    32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("hold.accept_in_ready",  32'(in_ready),  32'd1);
        checkOutput("hold.accept_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        checkRecord("hold.next", mkRec(8'h91, 0, 0, 0, 0, 16'h0, 3'b000, 2'b00, 0, 4'd1));
        takeRecord("hold.next");

        // Flush mid-instruction drops the prefix and the pending byte
        seq = '0; seq[0] = 8'h2E; seq[1] = 8'h8B;
        applyStimulus("flush", seq, 2);
        in_valid = 1'b1; in_data = 8'h46; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush.in_ready",  32'(in_ready),  32'd1);
        seq = '0; seq[0] = 8'h90;
        applyStimulus("flush.next", seq, 1);
        checkOutput("flush.next.valid", 32'(out_valid), 32'd1);
        checkRecord("flush.next", mkRec(8'h90, 0, 0, 0, 0, 16'h0, 3'b000, 2'b00, 0, 4'd1));
        takeRecord("flush.next");

        // Flush while holding beats out_ready
        seq = '0; seq[0] = 8'h2E; seq[1] = 8'h90;
        applyStimulus("flush_hold", seq, 2);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        checkOutput("flush_hold.out_valid", 32'(out_valid), 32'd0);
        checkRecord("flush_hold", zero_rec);

        // Reset mid-instruction
        seq = '0; seq[0] = 8'h2E; seq[1] = 8'h8B;
        applyStimulus("rst_mid", seq, 2);
        doReset();
        seq = '0; seq[0] = 8'h90;
        applyStimulus("rst_mid.next", seq, 1);
        checkRecord("rst_mid.next", mkRec(8'h90, 0, 0, 0, 0, 16'h0, 3'b000, 2'b00, 0, 4'd1));
        takeRecord("rst_mid.next");

        // Length saturation: 16 prefixes plus opcode
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'h2E;
            tick();
        end
        seq = '0; seq[0] = 8'h90;
        applyStimulus("sat", seq, 1);
        checkRecord("sat", mkRec(8'h90, 0, 0, 0, 0, 16'h0, 3'b101, 2'b00, 0, 4'd15));
        takeRecord("sat");

`ifdef MODRM_FETCH_REP_LOCK_EN
        seq = '0; seq[0] = 8'hF3; seq[1] = 8'h26; seq[2] = 8'hA4;
        applyStimulus("rep", seq, 3);
        checkRecord("rep", mkRec(8'hA4, 0, 0, 0, 0, 16'h0, 3'b100, 2'b11, 0, 4'd3));
        takeRecord("rep");
        seq = '0; seq[0] = 8'hF0; seq[1] = 8'hF2; seq[2] = 8'h90;
        applyStimulus("lock", seq, 3);
        checkRecord("lock", mkRec(8'h90, 0, 0, 0, 0, 16'h0, 3'b000, 2'b10, 1, 4'd3));
        takeRecord("lock");
`else
        seq = '0; seq[0] = 8'hF3;
        applyStimulus("rep_off", seq, 1);
        checkOutput("rep_off.out_valid", 32'(out_valid), 32'd1);
        checkRecord("rep_off", mkRec(8'hF3, 0, 0, 0, 0, 16'h0, 3'b000, 2'b00, 0, 4'd1));
        takeRecord("rep_off");
        seq = '0; seq[0] = 8'hF0;
        applyStimulus("lock_off", seq, 1);
        checkRecord("lock_off", mkRec(8'hF0, 0, 0, 0, 0, 16'h0, 3'b000, 2'b00, 0, 4'd1));
        takeRecord("lock_off");
`endif

        // Randomized stream against the instruction-level model
        for (int i = 0; i < 2048; i++) begin
            case ($urandom_range(0, 9))
                0:       stream[i] = 8'h26 + 8'(8 * $urandom_range(0, 3));
                1: begin
                    case ($urandom_range(0, 2))
                        0:       stream[i] = 8'hF0;
                        1:       stream[i] = 8'hF2;
                        default: stream[i] = 8'hF3;
                    endcase
                end
                2, 3, 4: stream[i] = hit_ops[$urandom_range(0, 7)];
                default: stream[i] = 8'($urandom);
            endcase
        end
        doReset();
        ptr = 0; mptr = 0; records = 0; cycles = 0;
        while (records < 150 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = stream[ptr];
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                e = modelDecode(mptr, used);
                checkRecord($sformatf("rand%0d", records), e);
                mptr += used;
                records++;
            end
            in_take = in_valid && in_ready;
            tick();
            if (in_take) ptr++;
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("rand.records", 32'(records), 32'd150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
